cache_mem_responder: RTL and testbench

Main-memory responder for the data-cache refill/write-back port of the RV32 core. Accepts one line-sized request at a time from the cache miss path, models a fixed access latency, then streams a line of read data back or absorbs a line of write-back data and acknowledges it. It is the memory-side end of the cache miss interface whose request and miss activity the core bench counts.

---
 rtl/cache_mem_responder.sv | 124 ++++++++++++
 tb/tb_cache_mem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: line-sized memory responder for the data-cache refill/write-back port.
// Fixed-latency read bursts and write-back absorption with a one-cycle commit pulse.
module cache_mem_responder #(
  parameter int LINE_WORDS = 8,
  parameter int MEM_AW     = 12,
  parameter int LATENCY    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_data_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        rd_last_o,
  output logic        wr_done_o,
  output logic        busy_o
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WDATA, WAIT, RBURST, WACK} state_e;

  state_e             state_q, state_d;
  logic [MEM_AW-1:0]  base_q, base_d;
  logic               write_q, write_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_last_q, rd_last_d;
  logic               wr_done_q, wr_done_d;
  logic [31:0]        mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]  addr;
  logic               unused_addr_bits;

  assign addr             = base_q + MEM_AW'(cnt_q);
  assign unused_addr_bits = ^{req_addr_i[31:MEM_AW+2], req_addr_i[1:0]};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    rd_last_d  = 1'b0;
    wr_done_d  = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        base_d  = req_addr_i[MEM_AW+1:2] & ~MEM_AW'(LINE_WORDS - 1);
        write_d = req_write_i;
        cnt_d   = '0;
        lat_d   = '0;
        state_d = req_write_i ? WDATA : WAIT;
      end
      WDATA: if (wr_valid_i) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(LINE_WORDS - 1)) ? WAIT : WDATA;
      end
      WAIT: begin
        lat_d = lat_q + 1'b1;
        // Final latency cycle launches the first registered response word.
        if (lat_q == LW'(LATENCY - 1)) begin
          lat_d      = '0;
          state_d    = write_q ? WACK : RBURST;
          wr_done_d  = write_q;
          rd_valid_d = !write_q;
          rd_data_d  = write_q ? '0 : mem_q[addr];
          cnt_d      = write_q ? cnt_q : cnt_q + 1'b1;
        end
      end
      RBURST: if (rd_last_q) begin
        state_d = IDLE;
      end else begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[addr];
        rd_last_d  = cnt_q == CW'(LINE_WORDS - 1);
        cnt_d      = cnt_q + 1'b1;
      end
      WACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      lat_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      wr_done_q  <= wr_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == WDATA && wr_valid_i) mem_q[addr] <= wr_data_i;
  end

  assign req_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign wr_done_o   = wr_done_q;
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed bench for cache_mem_responder with hand-computed lines.
module tb_cache_mem_responder;
  localparam int LAT = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
  logic [31:0] req_addr = '0, wr_data = '0;
  logic        req_ready, rd_valid, rd_last, wr_done, busy;
  logic [31:0] rd_data;
  logic [31:0] line [8];
  int          pass = 0, total = 0;

  cache_mem_responder #(.LINE_WORDS(8), .MEM_AW(12), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_last_o(rd_last), .wr_done_o(wr_done),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_line(input logic [31:0] addr, input int gap);
    int done_cnt = 0;
    chk("wr_ready", 32'(req_ready), 1);
    req_valid = 1; req_write = 1; req_addr = addr;
    tick;
    req_valid = 0; req_write = 0;
    chk("wr_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_data = line[i];
      tick;
      wr_valid = 0;
      if (i < 7) repeat (gap) tick;
    end
    for (int c = 1; c <= LAT; c++) begin
      tick;
      chk($sformatf("wr_done_c%0d", c), 32'(wr_done), 32'(c == LAT));
      done_cnt += int'(wr_done);
    end
    tick;
    chk("wr_done_after", 32'(wr_done), 0);
    chk("wr_idle_ready", 32'(req_ready), 1);
    chk("wr_done_once", 32'(done_cnt), 1);
  endtask

  task automatic rd_line(input logic [31:0] addr, input bit poke, input int abort_at);
    chk("rd_ready", 32'(req_ready), 1);
    req_valid = 1; req_write = 0; req_addr = addr;
    tick;
    req_valid = poke; req_addr = 32'h200;
    for (int c = 1; c < LAT; c++) begin
      tick;
      req_valid = 0;
      chk($sformatf("rd_wait_valid_c%0d", c), 32'(rd_valid), 0);
      chk($sformatf("rd_wait_ready_c%0d", c), 32'(req_ready), 0);
    end
    for (int w = 0; w < 8; w++) begin
      tick;
      chk($sformatf("rd_valid_w%0d", w), 32'(rd_valid), 1);
      chk($sformatf("rd_data_w%0d", w), rd_data, line[w]);
      chk($sformatf("rd_last_w%0d", w), 32'(rd_last), 32'(w == 7));
      if (w == abort_at) begin
        rst_n = 0;
        #1;
        chk("abort_valid", 32'(rd_valid), 0);
        chk("abort_data", rd_data, 0);
        chk("abort_busy", 32'(busy), 0);
        tick;
        rst_n = 1;
        tick;
        chk("abort_ready", 32'(req_ready), 1);
        return;
      end
    end
    tick;
    chk("rd_end_valid", 32'(rd_valid), 0);
    chk("rd_end_data", rd_data, 0);
    chk("rd_end_last", 32'(rd_last), 0);
    chk("rd_end_ready", 32'(req_ready), 1);
    if (poke) begin
      repeat (3) begin
        tick;
        chk("rd_no_second_line", 32'(rd_valid), 0);
      end
    end
  endtask

  initial begin
    repeat (3) begin
      req_valid = 1'($urandom_range(1)); req_write = 1'($urandom_range(1));
      wr_valid = 1'($urandom_range(1)); req_addr = $urandom; wr_data = $urandom;
      tick;
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_done", 32'(wr_done), 0);
      chk("rst_data", rd_data, 0);
    end
    req_valid = 0; req_write = 0; wr_valid = 0; req_addr = 0; wr_data = 0;
    rst_n = 1;
    tick;
    for (int i = 0; i < 8; i++) line[i] = 32'hA0 + 32'(i);
    wr_line(32'h100, 0);
    rd_line(32'h104, 0, -1);
    for (int i = 0; i < 8; i++) line[i] = 32'h11111111 * 32'(i + 1);
    wr_line(32'h200, 2);
    wr_valid = 1; wr_data = 32'hDEADBEEF;
    repeat (2) tick;
    wr_valid = 0;
    rd_line(32'h200, 0, -1);
    for (int i = 0; i < 8; i++) line[i] = 32'hA0 + 32'(i);
    rd_line(32'h104, 1, -1);
    for (int i = 0; i < 8; i++) line[i] = 32'hC0 + 32'(i);
    wr_line(32'h0, 1);
    rd_line(32'h4000, 0, -1);
    for (int i = 0; i < 8; i++) line[i] = 32'hA0 + 32'(i);
    rd_line(32'h100, 0, 2);
    rd_line(32'h104, 0, -1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
